// File: rtl/rgb_pattern_sequencer.sv
// AXI-Lite write-only master animating the four Arty A7 RGB LED registers with a colour wheel.
// Optional brightness scaling is enabled by defining RGBSEQ_BRIGHTNESS_EN.
module rgb_pattern_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int PERIOD_WIDTH       = 24,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RGB_BASE_ADDR = 6'h10
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,
    input  logic                            enable,
    input  logic [PERIOD_WIDTH-1:0]         period,
    input  logic [7:0]                      hue_step,
`ifdef RGBSEQ_BRIGHTNESS_EN
    input  logic [7:0]                      brightness,
`endif
    input  logic                            clear_flags,
    output logic                            busy,
    output logic                            err_flag,
    output logic                            overrun_flag,
    output logic [15:0]                     frame_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [3:0]                      m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, CALC, ISSUE, DONE} state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] timer;
    logic [PERIOD_WIDTH-1:0] terminal;
    logic [PERIOD_WIDTH-1:0] timer_next;
    logic                    tick;
    logic                    tick_pending;
    logic                    consume;
    logic [1:0]              led;
    logic [9:0]              hue_base;
    logic                    aw_done;
    logic                    w_done;
    logic                    b_done;
    logic                    aw_fin;
    logic                    w_fin;
    logic                    b_fin;
    logic                    err_set;
    logic                    unused_bresp;

    logic [10:0] hue_sum;
    logic [10:0] led_sum;
    logic [9:0]  hue_next;
    logic [9:0]  led_hue;
    logic [7:0]  f;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [7:0]  red_s;
    logic [7:0]  green_s;
    logic [7:0]  blue_s;

    assign m_axi_awprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;
    assign unused_bresp = m_axi_bresp[0];

    // A period of 0 behaves as 1, so the terminal count is then 0 and every enabled cycle ticks.
    assign terminal   = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
    assign timer_next = (timer >= terminal) ? '0 : timer + PERIOD_WIDTH'(1);
    assign tick       = enable && (timer_next == terminal);
    assign consume    = (state == WAIT_TICK) && enable && tick_pending;

    assign aw_fin  = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_fin   = w_done  | (m_axi_wvalid  & m_axi_wready);
    assign b_fin   = b_done  | m_axi_bvalid;
    assign err_set = (state == ISSUE) && m_axi_bvalid && m_axi_bresp[1];

    always_comb begin
        hue_sum  = {1'b0, hue_base} + {3'b000, hue_step};
        hue_next = (hue_sum >= 11'd768) ? 10'(hue_sum - 11'd768) : hue_sum[9:0];
        led_sum  = {1'b0, hue_base} + ({9'd0, led} * 11'd192);
        led_hue  = (led_sum >= 11'd768) ? 10'(led_sum - 11'd768) : led_sum[9:0];
        f        = led_hue[7:0];
        red      = 8'h00;
        green    = 8'h00;
        blue     = 8'h00;
        case (led_hue[9:8])
            2'd0:    begin red   = ~f; green = f;  end
            2'd1:    begin green = ~f; blue  = f;  end
            2'd2:    begin red   = f;  blue  = ~f; end
            default: ;
        endcase
    end

`ifdef RGBSEQ_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] p;
        p = {8'h00, c} * ({8'h00, br} + 16'd1);
        return 8'(p >> 8);
    endfunction

    assign red_s   = scale(red, brightness);
    assign green_s = scale(green, brightness);
    assign blue_s  = scale(blue, brightness);
`else
    assign red_s   = red;
    assign green_s = green;
    assign blue_s  = blue;
`endif

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            timer <= '0;
        end else if (enable) begin
            timer <= timer_next;
        end else begin
            timer <= '0;
        end
    end

    // Pending ticks are dropped while disabled so a re-enable starts a fresh period.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            tick_pending  <= 1'b0;
            err_flag      <= 1'b0;
            overrun_flag  <= 1'b0;
            frame_count   <= '0;
            hue_base      <= '0;
            led           <= '0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            b_done        <= 1'b0;
        end else begin
            tick_pending <= enable & (tick | (tick_pending & ~consume));

            if (clear_flags) begin
                overrun_flag <= 1'b0;
                err_flag     <= 1'b0;
            end else begin
                if (tick && tick_pending && !consume) overrun_flag <= 1'b1;
                if (err_set) err_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_TICK;
                        busy  <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick_pending) begin
                        led   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    m_axi_awaddr  <= RGB_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({led, 2'b00});
                    m_axi_wdata   <= C_M_AXI_DATA_WIDTH'({8'h00, red_s, green_s, blue_s});
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    m_axi_bready  <= 1'b1;
                    aw_done       <= 1'b0;
                    w_done        <= 1'b0;
                    b_done        <= 1'b0;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (m_axi_bvalid) b_done <= 1'b1;
                    // Enable is ignored here so a started frame always finishes its handshakes.
                    if (aw_fin && w_fin && b_fin) begin
                        m_axi_bready <= 1'b0;
                        if (led != 2'd3) begin
                            led   <= led + 2'd1;
                            state <= CALC;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    hue_base    <= hue_next;
                    frame_count <= frame_count + 16'd1;
                    state       <= enable ? WAIT_TICK : IDLE;
                    busy        <= enable;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
